// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the three-requester memory arbiter: FSM encodings,
// requester indices, default hold timeout and the modulo-3 index helper.
package mem_arbiter_pkg;

    typedef logic [1:0] req_idx_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam req_idx_t REQ_CPU    = 2'd0;
    localparam req_idx_t REQ_LOADER = 2'd1;
    localparam req_idx_t REQ_DEBUG  = 2'd2;

    localparam int LOCK_TIMEOUT_DEF = 15;

    function automatic req_idx_t next_idx(input req_idx_t i);
        return (i >= REQ_DEBUG) ? REQ_CPU : req_idx_t'(i + 2'd1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter; slave is the arbiter's
// view, master is the view of the environment driving requests and memory.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [2:0]      req;
    logic [2:0]      we;
    logic [2:0]      lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, lock, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select: first requester found searching upward from
// (ptr+1) mod 3; ptr = DEBUG turns this into fixed priority CPU > LOADER > DEBUG.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  req_idx_t   ptr,
    output req_idx_t   idx,
    output logic       vld
);
    req_idx_t c0, c1, c2;

    always_comb begin
        c0  = next_idx(ptr);
        c1  = next_idx(c0);
        c2  = next_idx(c1);
        idx = c0;
        if (req[c0])      idx = c0;
        else if (req[c1]) idx = c1;
        else if (req[c2]) idx = c2;
        vld = |req;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter for a 1-cycle synchronous memory with bus lock and
// hold timeout. Define MEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   owner,
    output logic         lock_err
);
    localparam logic [7:0] TIMEOUT_C = 8'(LOCK_TIMEOUT);

    logic [1:0]    state_q, state_d;
    req_idx_t      owner_q, owner_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d, hold_inc;
    logic          lock_err_q, lock_err_d;
    logic [2:0]    gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic          latch, post, own_req, own_lock, pick_vld;
    req_idx_t      latch_idx, pick_ptr, pick_idx;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_idx_t rr_ptr_q, rr_ptr_d;

    assign pick_ptr = rr_ptr_q;
    assign rr_ptr_d = latch ? latch_idx : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= REQ_DEBUG;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    assign pick_ptr = REQ_DEBUG;
`endif

    arb_pick u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        lock_err_d  = lock_err_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        latch       = 1'b0;
        latch_idx   = owner_q;
        post        = 1'b0;
        hold_inc    = hold_cnt_q + 8'd1;
        own_req     = bus.req[owner_q];
        own_lock    = bus.lock[owner_q];

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    latch     = 1'b1;
                    latch_idx = pick_idx;
                end
            end
            ST_ACCESS: begin
                if (!mem_we_q) begin
                    state_d  = ST_RESP;
                    rvalid_d = 3'b001 << owner_q;
                end else begin
                    post = 1'b1;
                end
            end
            ST_RESP: begin
                rdata_d = bus.mem_rdata;
                post    = 1'b1;
            end
            ST_HOLD: begin
                // Timeout outranks both a fresh owner request and a lock drop.
                if (hold_inc == TIMEOUT_C) begin
                    state_d    = ST_IDLE;
                    lock_err_d = 1'b1;
                    hold_cnt_d = '0;
                end else if (own_req) begin
                    latch = 1'b1;
                end else if (!own_lock) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (post) begin
            if (own_lock && own_req) latch   = 1'b1;
            else if (own_lock)       state_d = ST_HOLD;
            else                     state_d = ST_IDLE;
        end

        if (latch) begin
            state_d     = ST_ACCESS;
            owner_d     = latch_idx;
            mem_addr_d  = bus.addr[latch_idx*AW +: AW];
            mem_wdata_d = bus.wdata[latch_idx*DW +: DW];
            mem_we_d    = bus.we[latch_idx];
            gnt_d       = 3'b001 << latch_idx;
            mem_en_d    = 1'b1;
            hold_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_DEBUG;
            hold_cnt_q  <= '0;
            lock_err_q  <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            lock_err_q  <= lock_err_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Read data passes straight through in RESP since memory returns it that cycle.
    assign bus.rdata     = (state_q == ST_RESP) ? bus.mem_rdata : rdata_q;
    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign owner         = owner_q;
    assign lock_err      = lock_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, reset mid-read, contention,
// lock burst, lock timeout, req+unlock in HOLD and lock drop from HOLD.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] owner;
    logic       lock_err;
    int         n_chk = 0;
    int         n_bad = 0;
    logic [DW-1:0] mem [256];
    int         exp_g [4];
    int         exp_wd [4];

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .owner    (owner),
        .lock_err (lock_err)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous memory
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
        bus.req  = r;
        bus.we   = w;
        bus.lock = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h3C] = 8'hA5;
        reset     = 1'b1;
        bus.addr  = '0;
        bus.wdata = '0;
        drive(3'b000, 3'b000, 3'b000);
        tick();
        tick();

        chk_eq("rst_gnt",    32'(bus.gnt), 0);
        chk_eq("rst_rvalid", 32'(bus.rvalid), 0);
        chk_eq("rst_mem_en", 32'(bus.mem_en), 0);
        chk_eq("rst_mem_we", 32'(bus.mem_we), 0);
        chk_eq("rst_addr",   32'(bus.mem_addr), 0);
        chk_eq("rst_wdata",  32'(bus.mem_wdata), 0);
        chk_eq("rst_rdata",  32'(bus.rdata), 0);
        chk_eq("rst_owner",  32'(owner), 2);
        chk_eq("rst_lockerr", 32'(lock_err), 0);
        reset = 1'b0;

        // single read of 0x3C
        bus.addr = {8'h12, 8'h11, 8'h3C};
        drive(3'b001, 3'b000, 3'b000);
        tick();
        chk_eq("rd_gnt",    32'(bus.gnt), 32'h1);
        chk_eq("rd_mem_en", 32'(bus.mem_en), 1);
        chk_eq("rd_addr",   32'(bus.mem_addr), 32'h3C);
        chk_eq("rd_we",     32'(bus.mem_we), 0);
        chk_eq("rd_owner",  32'(owner), 0);
        drive(3'b000, 3'b000, 3'b000);
        tick();
        chk_eq("rd_rvalid", 32'(bus.rvalid), 32'h1);
        chk_eq("rd_rdata",  32'(bus.rdata), 32'hA5);
        chk_eq("rd_gnt0",   32'(bus.gnt), 0);
        tick();
        chk_eq("rd_rvalid0", 32'(bus.rvalid), 0);
        chk_eq("rd_hold",    32'(bus.rdata), 32'hA5);
        chk_eq("rd_en0",     32'(bus.mem_en), 0);

        // reset asserted while the read is in ACCESS
        drive(3'b001, 3'b000, 3'b000);
        tick();
        chk_eq("mr_gnt", 32'(bus.gnt), 32'h1);
        reset = 1'b1;
        drive(3'b000, 3'b000, 3'b000);
        tick();
        chk_eq("mr_rvalid", 32'(bus.rvalid), 0);
        chk_eq("mr_gnt0",   32'(bus.gnt), 0);
        chk_eq("mr_en",     32'(bus.mem_en), 0);
        chk_eq("mr_owner",  32'(owner), 2);
        chk_eq("mr_addr",   32'(bus.mem_addr), 0);
        chk_eq("mr_rdata",  32'(bus.rdata), 0);
        reset = 1'b0;
        tick();
        chk_eq("mr_rvalid1", 32'(bus.rvalid), 0);

        // contention: all three write, no lock
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g  = '{1, 2, 4, 1};
        exp_wd = '{32'h51, 32'h52, 32'h53, 32'h51};
`else
        exp_g  = '{1, 1, 1, 1};
        exp_wd = '{32'h51, 32'h51, 32'h51, 32'h51};
`endif
        bus.addr  = {8'h12, 8'h11, 8'h10};
        bus.wdata = {8'h53, 8'h52, 8'h51};
        drive(3'b111, 3'b111, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq("ct_gnt",   32'(bus.gnt), 32'(exp_g[i]));
            chk_eq("ct_wdata", 32'(bus.mem_wdata), 32'(exp_wd[i]));
            if (i == 3) drive(3'b000, 3'b000, 3'b000);
            tick();
            chk_eq("ct_gap", 32'(bus.gnt), 0);
        end

        // lock burst: CPU holds the bus for three writes while others wait
        drive(3'b001, 3'b111, 3'b001);
        tick();
        chk_eq("lb_gnt1", 32'(bus.gnt), 32'h1);
        drive(3'b111, 3'b111, 3'b001);
        tick();
        chk_eq("lb_gnt2", 32'(bus.gnt), 32'h1);
        tick();
        chk_eq("lb_gnt3", 32'(bus.gnt), 32'h1);
        drive(3'b110, 3'b111, 3'b000);
        tick();
        chk_eq("lb_idle", 32'(bus.gnt), 0);
        tick();
        chk_eq("lb_ldr",   32'(bus.gnt), 32'h2);
        chk_eq("lb_owner", 32'(owner), 1);
        drive(3'b000, 3'b000, 3'b000);
        tick();

        // lock timeout: 15 HOLD cycles, then loader
        drive(3'b001, 3'b011, 3'b001);
        tick();
        chk_eq("to_gnt", 32'(bus.gnt), 32'h1);
        drive(3'b010, 3'b011, 3'b001);
        for (int i = 0; i < LT; i++) begin
            tick();
            chk_eq("to_hold_gnt", 32'(bus.gnt), 0);
            chk_eq("to_hold_err", 32'(lock_err), 0);
        end
        tick();
        chk_eq("to_idle_gnt", 32'(bus.gnt), 0);
        chk_eq("to_err",      32'(lock_err), 1);
        tick();
        chk_eq("to_ldr",   32'(bus.gnt), 32'h2);
        chk_eq("to_owner", 32'(owner), 1);
        drive(3'b000, 3'b000, 3'b000);
        tick();
        chk_eq("to_sticky", 32'(lock_err), 1);

        reset = 1'b1;
        tick();
        chk_eq("r2_err",   32'(lock_err), 0);
        chk_eq("r2_owner", 32'(owner), 2);
        reset = 1'b0;

        // req and unlock together in HOLD: re-access, counter restarts
        bus.wdata = {8'h53, 8'h52, 8'h77};
        drive(3'b001, 3'b011, 3'b001);
        tick();
        chk_eq("ru_gnt1", 32'(bus.gnt), 32'h1);
        drive(3'b000, 3'b011, 3'b001);
        tick();
        tick();
        chk_eq("ru_hold", 32'(bus.gnt), 0);
        drive(3'b001, 3'b011, 3'b000);
        tick();
        chk_eq("ru_gnt2",  32'(bus.gnt), 32'h1);
        chk_eq("ru_wdata", 32'(bus.mem_wdata), 32'h77);
        drive(3'b010, 3'b011, 3'b001);
        for (int i = 0; i < LT; i++) begin
            tick();
            chk_eq("ru_hold_gnt", 32'(bus.gnt), 0);
            chk_eq("ru_hold_err", 32'(lock_err), 0);
        end
        tick();
        chk_eq("ru_err", 32'(lock_err), 1);
        tick();
        chk_eq("ru_ldr", 32'(bus.gnt), 32'h2);
        drive(3'b000, 3'b000, 3'b000);
        tick();

        // lock drop in HOLD releases the bus immediately
        drive(3'b001, 3'b011, 3'b001);
        tick();
        chk_eq("ld_gnt", 32'(bus.gnt), 32'h1);
        drive(3'b010, 3'b011, 3'b001);
        tick();
        chk_eq("ld_hold", 32'(bus.gnt), 0);
        drive(3'b010, 3'b011, 3'b000);
        tick();
        chk_eq("ld_idle", 32'(bus.gnt), 0);
        tick();
        chk_eq("ld_ldr", 32'(bus.gnt), 32'h2);
        drive(3'b000, 3'b000, 3'b000);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 15, max HOLD cycles before forced release (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req / we / lock  input  3 each  per-requester request, write-enable, bus-lock (bit0=CPU, bit1=loader, bit2=debug).
REQ-007 SHALL have ports addr  input  3*AW, and wdata  input  3*DW  flattened per-requester address/write data, requester i at slice i.
REQ-008 SHALL have port gnt  output  3  one-hot one-cycle acceptance pulse.
REQ-009 SHALL have ports rvalid  output  3, and rdata  output  DW  read-return pulse and shared read data.
REQ-010 SHALL have ports mem_en, mem_we  output  1 each; mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW  (1-cycle synchronous read memory).
REQ-011 SHALL have ports owner  output  2  current/last owner index; lock_err  output  1  sticky lock-timeout flag.

Function
REQ-012 SHALL implement states IDLE, ACCESS, RESP, HOLD.
REQ-013 IDLE: when any req is high, SHALL select a winner, register its addr/wdata/we into mem_addr/mem_wdata/mem_we, set owner, and enter ACCESS next cycle; with no req, SHALL stay in IDLE.
REQ-014 ACCESS, exactly 1 cycle: SHALL assert mem_en=1 and gnt[owner]=1.
REQ-015 The transaction SHALL commit once latched; a req drop during ACCESS SHALL NOT cancel it.
REQ-016 After ACCESS: read SHALL go to RESP; write SHALL go to post-access decision (REQ-018).
REQ-017 RESP, 1 cycle: SHALL assert rvalid[owner]=1 and rdata=mem_rdata; rdata SHALL hold its last value otherwise.
REQ-018 Post-access decision: lock[owner]&req[owner] SHALL latch owner again and enter ACCESS; lock[owner]&!req[owner] SHALL enter HOLD; !lock[owner] SHALL enter IDLE.
REQ-019 Latency: write req-to-gnt 1 cycle, 2 cycles/access; read req-to-rvalid 2 cycles, 3 cycles/access.
REQ-020 HOLD: SHALL ignore other requesters; owner req SHALL latch and enter ACCESS; lock drop SHALL enter IDLE.
REQ-021 HOLD: an 8-bit counter SHALL increment each HOLD cycle; on reaching LOCK_TIMEOUT it SHALL force IDLE and set lock_err=1.
REQ-022 The HOLD counter SHALL clear on any HOLD exit.
REQ-023 If owner req and lock-drop occur together in HOLD, req SHALL win (ACCESS); a completing timeout SHALL take precedence over both.
REQ-024 Outputs gnt, rvalid, mem_en SHALL be registered one-hot/zero, never more than one gnt or rvalid bit high.

Reset
REQ-025 On reset, at any state including mid-ACCESS or mid-HOLD, the block SHALL enter IDLE next cycle.
REQ-026 On reset: gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, owner=2, HOLD counter=0, lock_err=0, round-robin pointer=2.
REQ-027 An in-flight read interrupted by reset SHALL produce no rvalid.

Configuration
REQ-028 With macro MEM_ARB_ROUND_ROBIN_EN defined, winner selection SHALL be round-robin starting at (last owner+1) mod 3, updating the pointer on each grant.
REQ-029 Without MEM_ARB_ROUND_ROBIN_EN, winner selection SHALL be fixed priority 0 > 1 > 2 and the pointer logic SHALL be absent.

Structure
REQ-030 State encodings, requester index constants (CPU=0, LOADER=1, DEBUG=2) and the default LOCK_TIMEOUT SHALL live in the shared package/header.
REQ-031 Winner selection SHALL be a combinational sub-module arb_pick (inputs req, pointer; output index, valid), instantiated once.

Verification
REQ-032 Single read: req=001, we=0, addr0=0x3C, mem_rdata=0xA5 -> gnt=001 at cycle+1, mem_addr=0x3C, rvalid=001 and rdata=0xA5 at cycle+2.
REQ-033 Contention: req=111, writes, held -> fixed mode grants 0,0,0...; RR mode grants 0,1,2,0 every 2 cycles.
REQ-034 Lock burst: CPU lock=1, 3 back-to-back writes while req=110 -> gnt=001 three times, no gnt to 1/2 until lock drops.
REQ-035 Lock timeout: CPU lock=1, req=0 after 1 write, LOCK_TIMEOUT=15 -> 15 HOLD cycles then IDLE, lock_err=1, loader granted next.
REQ-036 Reset mid-read: reset asserted in ACCESS -> no rvalid, all outputs 0, owner=2 next cycle.
REQ-037 Simultaneous req+unlock in HOLD -> ACCESS for owner, counter=0.
